// File: rtl/flush_ctrl_unit_pkg.sv
// Shared types and constants for the flush/redirect controller and its arbiter.
package flush_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_REMAP  = 2'd2,
    ST_RESUME = 2'd3
  } fcu_state_e;

  localparam int STG_FTQ       = 0;
  localparam int STG_BPCHECK   = 1;
  localparam int STG_INSTQUEUE = 2;
  localparam int STG_DECODE    = 3;
  localparam int STG_DISPATCH  = 4;
  localparam int STG_ALLRS     = 5;
  localparam int STG_EU        = 6;
  localparam int STG_LSU       = 7;

  localparam logic AbleValue   = 1'b1;
  localparam logic EnableValue = 1'b1;

endpackage

// File: rtl/flush_ctrl_unit_prio_arb.sv
// Fixed-priority arbiter: lowest set request index wins; one-hot and encoded grant.
module flush_prio_arb #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    // Walk from the lowest priority up so the highest-priority request wins last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = IW'(i);
      end
    end
    gnt_vld_o = |req_i;
  end

endmodule

// File: rtl/flush_ctrl_unit.sv
// Flush/redirect controller: priority flush grant, per-stage flush pulse, aRAT remap handshake.
// Optional FLUSH_STAT_EN adds per-source flush counters and a REMAP cycle counter.
module flush_ctrl_unit
  import flush_ctrl_unit_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int NUM_SRC    = 3,
  parameter int ADDR_W     = 32,
  parameter logic [NUM_SRC*NUM_STAGES-1:0] SRC_STAGE_MASK = '1,
  parameter logic [NUM_SRC-1:0]            SRC_REMAP_MASK = 3'b001,
  parameter int REMAP_MIN_CYC = 2,
  localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      Clk,
  input  logic                      Rest,
  input  logic [NUM_SRC-1:0]        SrcReq,
  input  logic [NUM_SRC*ADDR_W-1:0] SrcPc,
  input  logic                      RemapAck,
  output logic [NUM_STAGES-1:0]     StageFlush,
  output logic                      RedirectValid,
  output logic [ADDR_W-1:0]         RedirectPc,
  output logic                      aRATRemapping,
  output logic                      FrontStall,
  output logic                      Busy,
`ifdef FLUSH_STAT_EN
  output logic [NUM_SRC*32-1:0]     FlushCnt,
  output logic [31:0]               RemapCycCnt,
`endif
  output logic [GW-1:0]             GrantSrc
);

  localparam int CW = $clog2(REMAP_MIN_CYC + 1);
  localparam logic [CW-1:0] MIN_C = CW'(REMAP_MIN_CYC);

  fcu_state_e         state_q, state_d;
  logic [GW-1:0]      win_q, win_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sticky_q, sticky_d;

  logic [NUM_SRC-1:0] gnt_oh;
  logic [GW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [ADDR_W-1:0]  pc_sel;

  flush_prio_arb #(.N(NUM_SRC), .IW(GW)) u_arb (
    .req_i     (SrcReq),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    pc_sel = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (gnt_oh[s]) pc_sel = pc_sel | SrcPc[s*ADDR_W +: ADDR_W];
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    sticky_d      = sticky_q;
    StageFlush    = '0;
    RedirectValid = 1'b0;
    RedirectPc    = '0;
    aRATRemapping = 1'b0;
    FrontStall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          win_d   = gnt_idx;
          pc_d    = pc_sel;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        StageFlush    = SRC_STAGE_MASK[win_q*NUM_STAGES +: NUM_STAGES];
        RedirectValid = 1'b1;
        RedirectPc    = pc_q;
        FrontStall    = 1'b1;
        cnt_d         = CW'(1);
        sticky_d      = 1'b0;
        state_d       = SRC_REMAP_MASK[win_q] ? ST_REMAP : ST_RESUME;
      end
      ST_REMAP: begin
        aRATRemapping = 1'b1;
        FrontStall    = 1'b1;
        if (cnt_q >= MIN_C && (RemapAck || sticky_q)) begin
          sticky_d = 1'b0;
          state_d  = ST_RESUME;
        end else begin
          // An ack arriving before the minimum hold is kept until the minimum is reached.
          sticky_d = sticky_q | RemapAck;
          if (cnt_q < MIN_C) cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        FrontStall = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign GrantSrc = win_q;

`ifdef FLUSH_STAT_EN
  logic [NUM_SRC-1:0][31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]              remap_cyc_q, remap_cyc_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    remap_cyc_d = remap_cyc_q;
    for (int s = 0; s < NUM_SRC; s++)
      if (state_q == ST_IDLE && gnt_vld && gnt_idx == GW'(s) && flush_cnt_q[s] != 32'hFFFF_FFFF)
        flush_cnt_d[s] = flush_cnt_q[s] + 32'd1;
    if (state_q == ST_REMAP && remap_cyc_q != 32'hFFFF_FFFF)
      remap_cyc_d = remap_cyc_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      flush_cnt_q <= '0;
      remap_cyc_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      remap_cyc_q <= remap_cyc_d;
    end
  end

  assign FlushCnt    = flush_cnt_q;
  assign RemapCycCnt = remap_cyc_q;
`endif

endmodule

// File: tb/tb_flush_ctrl_unit.sv
// Randomized self-checking bench for flush_ctrl_unit against a transaction-level timeline model.
module tb_flush_ctrl_unit;

  localparam int NS = 8, NSRC = 3, AW = 32, GW = 2, MIN = 2;
  localparam logic [23:0] MASKS = 24'h3C_7F_FF;
  localparam logic [2:0]  RMAP  = 3'b001;

  logic          Clk = 1'b0;
  logic          Rest;
  logic [2:0]    SrcReq;
  logic [95:0]   SrcPc;
  logic          RemapAck;
  logic [7:0]    StageFlush;
  logic          RedirectValid;
  logic [31:0]   RedirectPc;
  logic          aRATRemapping;
  logic          FrontStall;
  logic          Busy;
  logic [GW-1:0] GrantSrc;
`ifdef FLUSH_STAT_EN
  logic [95:0]   FlushCnt;
  logic [31:0]   RemapCycCnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int last_w = 0;
  int m_cnt[3];
  int m_rcyc = 0;

  flush_ctrl_unit #(
    .NUM_STAGES(NS), .NUM_SRC(NSRC), .ADDR_W(AW),
    .SRC_STAGE_MASK(MASKS), .SRC_REMAP_MASK(RMAP), .REMAP_MIN_CYC(MIN)
  ) dut (
    .Clk(Clk), .Rest(Rest), .SrcReq(SrcReq), .SrcPc(SrcPc), .RemapAck(RemapAck),
    .StageFlush(StageFlush), .RedirectValid(RedirectValid), .RedirectPc(RedirectPc),
    .aRATRemapping(aRATRemapping), .FrontStall(FrontStall), .Busy(Busy),
`ifdef FLUSH_STAT_EN
    .FlushCnt(FlushCnt), .RemapCycCnt(RemapCycCnt),
`endif
    .GrantSrc(GrantSrc)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic exp_out(input string ph, input logic [7:0] sf, input logic rv,
                         input logic [31:0] pc, input logic rm, input logic fs, input logic bz);
    check({ph, ".flush"}, 64'(StageFlush), 64'(sf));
    check({ph, ".rv"},    64'(RedirectValid), 64'(rv));
    check({ph, ".pc"},    64'(RedirectPc), 64'(pc));
    check({ph, ".remap"}, 64'(aRATRemapping), 64'(rm));
    check({ph, ".stall"}, 64'(FrontStall), 64'(fs));
    check({ph, ".busy"},  64'(Busy), 64'(bz));
    check({ph, ".grant"}, 64'(GrantSrc), 64'(last_w));
  endtask

`ifdef FLUSH_STAT_EN
  task automatic chk_stats(input string tag);
    logic [95:0] fc;
    logic [95:0] sh;
    fc = FlushCnt;
    for (int s = 0; s < 3; s++) begin
      sh = fc >> (32 * s);
      check({tag, ".flushcnt"}, 64'(sh[31:0]), 64'(m_cnt[s]));
    end
    check({tag, ".remapcyc"}, 64'(RemapCycCnt), 64'(m_rcyc));
  endtask
`endif

  // One request presented in IDLE, then the full expected flush timeline.
  task automatic run_txn(input logic [2:0] req, input logic [95:0] pcs, input int ack_cyc);
    int w, rlen;
    logic [23:0] m;
    logic [95:0] p;
    logic [2:0]  rm_v;
    logic [31:0] wpc;
    SrcReq   = req;
    SrcPc    = pcs;
    RemapAck = 1'($urandom);
    #2;
    exp_out("idle", 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;
    if (req == 3'b000) return;
    w = 0;
    while (!req[w]) w++;
    m    = MASKS >> (8 * w);
    p    = pcs >> (AW * w);
    wpc  = p[31:0];
    rm_v = RMAP;
    rlen = rm_v[w] ? ((ack_cyc > MIN) ? ack_cyc : MIN) : 0;
    last_w = w;
    m_cnt[w]++;
    m_rcyc += rlen;
    for (int i = 0; i <= rlen + 1; i++) begin
      SrcReq = 3'($urandom);
      SrcPc  = {$urandom, $urandom, $urandom};
      if (i >= 1 && i <= rlen)
        RemapAck = (i == ack_cyc) || (i > ack_cyc && 1'($urandom));
      else
        RemapAck = 1'($urandom);
      #2;
      if (i == 0)         exp_out("flush",  m[7:0], 1'b1, wpc,   1'b0, 1'b1, 1'b1);
      else if (i <= rlen) exp_out("remap",  8'h00,  1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      else                exp_out("resume", 8'h00,  1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      tick;
    end
  endtask

  function automatic logic [95:0] rnd_pcs();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    for (int s = 0; s < 3; s++) m_cnt[s] = 0;
    Rest = 1'b1; SrcReq = 3'b111; SrcPc = '0; RemapAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      #2;
      exp_out("reset", 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    Rest = 1'b0; SrcReq = 3'b000;
    tick;
`ifdef FLUSH_STAT_EN
    chk_stats("reset");
`endif

    run_txn(3'b010, {32'h2000_0000, 32'h1C00_0040, 32'h3000_0000}, 1);
    run_txn(3'b001, {32'h2000_0000, 32'h1C00_0040, 32'h8000_0100}, 5);
    run_txn(3'b001, rnd_pcs(), 1);
    run_txn(3'b110, {32'h2222_0000, 32'h1111_0000, 32'h0}, 1);
    run_txn(3'b001, rnd_pcs(), 3);
    run_txn(3'b000, rnd_pcs(), 1);
    run_txn(3'b100, rnd_pcs(), 1);

    // Reset asserted in the second REMAP cycle aborts to IDLE.
    SrcReq = 3'b001; SrcPc = rnd_pcs(); RemapAck = 1'b0;
    tick;
    SrcReq = 3'b000;
    tick;
    tick;
    Rest = 1'b1;
    #2;
    last_w = 0;
    check("midrst.remap_before", 64'(aRATRemapping), 64'(1));
    tick;
    Rest = 1'b0;
    for (int s = 0; s < 3; s++) m_cnt[s] = 0;
    m_rcyc = 0;
    #2;
    exp_out("midrst", 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick;

    for (int k = 0; k < 3; k++) run_txn(3'b001, rnd_pcs(), $urandom_range(1, 4));
`ifdef FLUSH_STAT_EN
    chk_stats("rob3");
`endif

    for (int k = 0; k < 150; k++)
      run_txn(3'($urandom_range(0, 7)), rnd_pcs(), $urandom_range(1, 6));
    run_txn(3'b000, rnd_pcs(), 1);
`ifdef FLUSH_STAT_EN
    chk_stats("final");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
